uart_core: RTL and testbench
============================

Name: uart_core

Overview:
Parametrised successor to the fixed 8N1/115200 UART pair. Adds run-time baud divisor, configurable data width, parity and stop bits, 3-sample majority-voted oversampled receive, false-start rejection, TX/RX FIFOs, and per-byte parity/framing error flags plus a sticky overrun flag. Sits between the 6502 bus register front-end and the tx/rx pins. Bus decoding stays outside this block.

Parameters:
DATA_BITS, 8, data bits per frame, 5..8, LSB first on the line
DIV_WIDTH, 16, width of the divisor input
OVERSAMPLE, 16, oversample ticks per bit; even, >=8
FIFO_AW, 4, log2 of depth for both TX and RX FIFOs (depth 16)

Ports:
clk  in  1  system clock, 16 MHz
rst  in  1  asynchronous, active-high reset
divisor  in  DIV_WIDTH  oversample tick period minus 1, in clk cycles
parity_en  in  1  1 = parity bit present
parity_odd  in  1  1 = odd parity, 0 = even
two_stop  in  1  TX sends 2 stop bits; RX always checks only the first
tx_data  in  DATA_BITS  byte to transmit
tx_valid  in  1  push request into the TX FIFO
tx_ready  out  1  TX FIFO not full
tx_busy  out  1  TX FIFO non-empty or a frame is in flight
tx  out  1  serial out, idle high
rx  in  1  serial in, asynchronous
rx_data  out  DATA_BITS  RX FIFO head (show-ahead)
rx_parity_err  out  1  parity error flag of the head entry
rx_frame_err  out  1  framing error flag of the head entry
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  pop the head when rx_valid is high
rx_overrun  out  1  sticky; set when a byte is dropped
overrun_clr  in  1  clears rx_overrun

Behaviour:
- Reset (asynchronous): tx=1; tx_ready=1; tx_busy=0; rx_valid=0; rx_data=0; both error flags 0; rx_overrun=0; both FIFOs empty; both FSMs idle; tick counter 0. A reset mid-frame aborts the frame immediately.
- Tick generator: free-running counter. Pulses for 1 clk every divisor+1 clks. A new divisor value applies at the next counter wrap.
- TX FSM (IDLE, START, DATA, PARITY, STOP1, STOP2):
  - A push occurs when tx_valid && tx_ready.
  - In IDLE with the FIFO non-empty: pop the FIFO and load the shifter on the next tick. tx drops on that tick.
  - Each state lasts OVERSAMPLE ticks.
  - PARITY is skipped if !parity_en. Parity bit = XOR(data) ^ parity_odd.
  - STOP2 is taken only if two_stop.
  - Back-to-back frames run with no idle gap.
  - Config inputs are sampled at frame load.
- RX input: rx passes through a 2-flop synchronizer. Edge detection runs on the synchronized value.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE -> START on a 1->0 synchronized edge. The tick phase counter resets to 0.
  - Sample value = majority of ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of each bit.
  - START: if the voted value is 1, this is a false start; return to IDLE with no push.
  - DATA: collect DATA_BITS bits, LSB first.
  - PARITY: present only if parity_en. Mismatch sets the entry's parity_err.
  - STOP: a voted 0 sets frame_err.
  - At the STOP sample tick: push {frame_err, parity_err, data} and go to IDLE. The next start edge is accepted immediately.
  - The byte is pushed even when it carries errors.
- RX FIFO:
  - A push into a full FIFO is dropped and sets rx_overrun.
  - Pop and push in the same cycle while full: both are accepted, no overrun.
  - overrun_clr and a new overrun in the same cycle: the flag stays set.
- TX FIFO: a push while full is ignored, since tx_ready=0. Pop and push in the same cycle keep the count unchanged.
- FIFO pointers are FIFO_AW+1 bits, so they wrap naturally; full and empty are distinguished by the MSB.
- Latency: the synchronized stop sample to rx_valid is 1 clk. A push into an idle TX to the tx falling edge is at most divisor+2 clks.

Test Plan:
- Reset, divisor=0, 8N1, push 0xA5, loop tx->rx -> tx low 16 clks then 1,0,1,0,0,1,0,1 (16 clks each), then high. rx_valid with rx_data=0xA5, no errors; tx_busy falls after the stop bit.
- parity_en=1, even, push 0x03 -> parity bit 0. With odd -> parity bit 1. Drive rx with 0x03 and parity 1 under even -> rx_parity_err=1, rx_data=0x03.
- Drive rx start plus 0x55 with stop=0 -> rx_frame_err=1, rx_data=0x55. A following valid 0x12 -> no errors.
- rx low for 4 ticks then high -> no push. A 1-tick glitch at bit centre of 0x00 data -> received 0x00.
- Send 17 bytes 0x00..0x10 to RX without popping -> rx_overrun=1. Popping returns 0x00..0x0F in order, then rx_valid=0. overrun_clr -> 0.
- Push 3 bytes with two_stop=1, assert rst mid-second-frame -> tx=1 at once, tx_busy=0, tx_ready=1, FIFO empty, no further frames.

Source files
------------

// File: rtl/uart_core_if.sv
// rtl/uart_core_if.sv - bus-side configuration, TX push, RX pop and status bundle of uart_core
interface uart_core_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] divisor;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 two_stop;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_overrun;
    logic                 overrun_clr;

    modport master (
        output divisor, parity_en, parity_odd, two_stop,
        output tx_data, tx_valid, rx_ready, overrun_clr,
        input  tx_ready, tx_busy, rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun
    );

    modport slave (
        input  divisor, parity_en, parity_odd, two_stop,
        input  tx_data, tx_valid, rx_ready, overrun_clr,
        output tx_ready, tx_busy, rx_data, rx_parity_err, rx_frame_err, rx_valid, rx_overrun
    );
endinterface

// File: rtl/uart_core.sv
// rtl/uart_core.sv - configurable UART with oversampled majority-vote receive and TX/RX FIFOs
module uart_core #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    uart_core_if.slave  bus,
    output logic        tx,
    input  logic        rx
);
    localparam int PW    = $clog2(OVERSAMPLE);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int EW    = DATA_BITS + 2;

    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [PW-1:0] PH_S0   = PW'(OVERSAMPLE / 2 - 1);
    localparam logic [PW-1:0] PH_S1   = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0] PH_S2   = PW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP1  = 3'd4;
    localparam logic [2:0] TX_STOP2  = 3'd5;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;

    // Oversample tick; the divisor is latched at each wrap so a change never truncates a period.
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_q;
    logic                 tick;

    assign tick = (div_cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            div_q   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= bus.divisor;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // TX FIFO
    logic [DATA_BITS-1:0] txf_mem [DEPTH];
    logic [FIFO_AW:0]     txf_wr;
    logic [FIFO_AW:0]     txf_rd;
    logic                 txf_empty;
    logic                 txf_full;
    logic                 txf_push;
    logic                 tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign txf_empty    = (txf_wr == txf_rd);
    assign txf_full     = (txf_wr[FIFO_AW] != txf_rd[FIFO_AW]) &&
                          (txf_wr[FIFO_AW-1:0] == txf_rd[FIFO_AW-1:0]);
    assign bus.tx_ready = !txf_full;
    assign txf_push     = bus.tx_valid && !txf_full;
    assign tx_head      = txf_mem[txf_rd[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (txf_push) begin
            txf_mem[txf_wr[FIFO_AW-1:0]] <= bus.tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txf_wr <= '0;
            txf_rd <= '0;
        end else begin
            if (txf_push) txf_wr <= txf_wr + 1'b1;
            if (tx_pop)   txf_rd <= txf_rd + 1'b1;
        end
    end

    // TX FSM
    logic [2:0]           tx_state;
    logic [PW-1:0]        tx_phase;
    logic [BW-1:0]        tx_bitcnt;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;
    logic                 tx_pe;
    logic                 tx_ts;
    logic                 tx_bit_end;
    logic                 tx_last_stop;

    assign tx_bit_end   = tick && (tx_phase == PH_LAST);
    assign tx_last_stop = (tx_state == TX_STOP2) || ((tx_state == TX_STOP1) && !tx_ts);
    // The next frame is loaded on the last tick of the final stop bit, so frames run back to back.
    assign tx_pop       = !txf_empty &&
                          (((tx_state == TX_IDLE) && tick) || (tx_last_stop && tx_bit_end));
    assign bus.tx_busy  = !txf_empty || (tx_state != TX_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx        <= 1'b1;
            tx_phase  <= '0;
            tx_bitcnt <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_pe     <= 1'b0;
            tx_ts     <= 1'b0;
        end else if (tx_pop) begin
            tx_state  <= TX_START;
            tx        <= 1'b0;
            tx_phase  <= '0;
            tx_shift  <= tx_head;
            tx_par    <= ^tx_head ^ bus.parity_odd;
            tx_pe     <= bus.parity_en;
            tx_ts     <= bus.two_stop;
        end else if ((tx_state != TX_IDLE) && tick) begin
            if (tx_phase != PH_LAST) begin
                tx_phase <= tx_phase + 1'b1;
            end else begin
                tx_phase <= '0;
                case (tx_state)
                    TX_START: begin
                        tx_state  <= TX_DATA;
                        tx        <= tx_shift[0];
                        tx_bitcnt <= '0;
                    end
                    TX_DATA: begin
                        if (tx_bitcnt == BIT_LAST) begin
                            tx_state <= tx_pe ? TX_PARITY : TX_STOP1;
                            tx       <= tx_pe ? tx_par : 1'b1;
                        end else begin
                            tx_bitcnt <= tx_bitcnt + 1'b1;
                            tx_shift  <= tx_shift >> 1;
                            tx        <= tx_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state <= TX_STOP1;
                        tx       <= 1'b1;
                    end
                    TX_STOP1: begin
                        tx_state <= tx_ts ? TX_STOP2 : TX_IDLE;
                        tx       <= 1'b1;
                    end
                    default: begin
                        tx_state <= TX_IDLE;
                        tx       <= 1'b1;
                    end
                endcase
            end
        end
    end

    // RX synchronizer; rx_s3 only provides the previous value for edge detection.
    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // RX FSM
    logic [2:0]           rx_state;
    logic [PW-1:0]        rx_phase;
    logic [BW-1:0]        rx_bitcnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_v0;
    logic                 rx_v1;
    logic                 rx_vote;
    logic                 rx_perr;
    logic                 rx_push;
    logic [EW-1:0]        rx_entry;

    assign rx_vote  = (rx_v0 & rx_v1) | (rx_v0 & rx_s2) | (rx_v1 & rx_s2);
    assign rx_push  = (rx_state == RX_STOP) && tick && (rx_phase == PH_S2);
    assign rx_entry = {!rx_vote, rx_perr, rx_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            rx_phase  <= '0;
            rx_bitcnt <= '0;
            rx_shift  <= '0;
            rx_v0     <= 1'b1;
            rx_v1     <= 1'b1;
            rx_perr   <= 1'b0;
        end else if (rx_state == RX_IDLE) begin
            if (rx_s3 && !rx_s2) begin
                rx_state <= RX_START;
                rx_phase <= '0;
                rx_perr  <= 1'b0;
            end
        end else if (tick) begin
            rx_phase <= (rx_phase == PH_LAST) ? '0 : rx_phase + 1'b1;
            if (rx_phase == PH_S0) begin
                rx_v0 <= rx_s2;
            end else if (rx_phase == PH_S1) begin
                rx_v1 <= rx_s2;
            end else if (rx_phase == PH_S2) begin
                case (rx_state)
                    RX_START:  if (rx_vote) rx_state <= RX_IDLE;
                    RX_DATA:   rx_shift <= {rx_vote, rx_shift[DATA_BITS-1:1]};
                    RX_PARITY: rx_perr  <= (rx_vote != (^rx_shift ^ bus.parity_odd));
                    default:   rx_state <= RX_IDLE;
                endcase
            end else if (rx_phase == PH_LAST) begin
                case (rx_state)
                    RX_START: begin
                        rx_state  <= RX_DATA;
                        rx_bitcnt <= '0;
                    end
                    RX_DATA: begin
                        if (rx_bitcnt == BIT_LAST) begin
                            rx_state <= bus.parity_en ? RX_PARITY : RX_STOP;
                        end else begin
                            rx_bitcnt <= rx_bitcnt + 1'b1;
                        end
                    end
                    default: rx_state <= RX_STOP;
                endcase
            end
        end
    end

    // RX FIFO; a pop frees the slot a same-cycle push needs, so full+pop+push is not an overrun.
    logic [EW-1:0]    rxf_mem [DEPTH];
    logic [FIFO_AW:0] rxf_wr;
    logic [FIFO_AW:0] rxf_rd;
    logic             rxf_empty;
    logic             rxf_full;
    logic             rxf_pop;
    logic             rxf_wen;
    logic [EW-1:0]    rxf_head;

    assign rxf_empty = (rxf_wr == rxf_rd);
    assign rxf_full  = (rxf_wr[FIFO_AW] != rxf_rd[FIFO_AW]) &&
                       (rxf_wr[FIFO_AW-1:0] == rxf_rd[FIFO_AW-1:0]);
    assign rxf_pop   = bus.rx_ready && !rxf_empty;
    assign rxf_wen   = rx_push && (!rxf_full || rxf_pop);
    assign rxf_head  = rxf_empty ? '0 : rxf_mem[rxf_rd[FIFO_AW-1:0]];

    assign bus.rx_valid      = !rxf_empty;
    assign bus.rx_data       = rxf_head[DATA_BITS-1:0];
    assign bus.rx_parity_err = rxf_head[DATA_BITS];
    assign bus.rx_frame_err  = rxf_head[DATA_BITS+1];

    always_ff @(posedge clk) begin
        if (rxf_wen) begin
            rxf_mem[rxf_wr[FIFO_AW-1:0]] <= rx_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxf_wr         <= '0;
            rxf_rd         <= '0;
            bus.rx_overrun <= 1'b0;
        end else begin
            if (rxf_wen) rxf_wr <= rxf_wr + 1'b1;
            if (rxf_pop) rxf_rd <= rxf_rd + 1'b1;
            if (rx_push && rxf_full && !rxf_pop) begin
                bus.rx_overrun <= 1'b1;
            end else if (bus.overrun_clr) begin
                bus.rx_overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_core.sv
// tb/tb_uart_core.sv - self-checking bench for uart_core: vector table, loopback model, random frames
module tb_uart_core;
    logic clk = 1'b0;
    logic rst;
    logic tx_w;
    logic rx_drv;
    logic loop_en;
    logic rx_line;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_w : rx_drv;

    uart_core_if #(.DATA_BITS(8), .DIV_WIDTH(16)) bus ();

    uart_core #(.DATA_BITS(8), .DIV_WIDTH(16), .OVERSAMPLE(16), .FIFO_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx_w),
        .rx  (rx_line)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int bit_clks = 16;
    int cur_div  = 0;
    logic exp_bits[$];

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       po;
        logic       pb;
        logic       sb;
        int         gl;
        logic [7:0] ed;
        logic       eperr;
        logic       eferr;
    } rx_vec_t;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    rx_vec_t vt[8];
    rx_exp_t rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void frame_bits(input logic [7:0] d, input logic pe, input logic po,
                                       input logic ts);
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pe) exp_bits.push_back(^d ^ po);
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);
    endfunction

    task automatic set_cfg(input int div, input logic pe, input logic po, input logic ts);
        @(negedge clk);
        bus.divisor    = 16'(div);
        bus.parity_en  = pe;
        bus.parity_odd = po;
        bus.two_stop   = ts;
        cur_div  = div;
        bit_clks = (div + 1) * 16;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic check_rx(input string name, input logic [7:0] d, input logic perr,
                            input logic ferr);
        check({name, "_valid"}, bus.rx_valid, 1'b1);
        check({name, "_data"}, bus.rx_data, d);
        check({name, "_perr"}, bus.rx_parity_err, perr);
        check({name, "_ferr"}, bus.rx_frame_err, ferr);
        pop_rx();
    endtask

    task automatic drive_bit(input logic v, input logic glitch);
        rx_drv = v;
        if (glitch) begin
            repeat (bit_clks / 2) @(negedge clk);
            rx_drv = ~v;
            repeat (bit_clks / 16) @(negedge clk);
            rx_drv = v;
            repeat (bit_clks / 2 - bit_clks / 16) @(negedge clk);
        end else begin
            repeat (bit_clks) @(negedge clk);
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic pe, input logic pb, input logic sb,
                           input int gl);
        @(negedge clk);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], gl == i);
        if (pe) drive_bit(pb, 1'b0);
        drive_bit(sb, 1'b0);
        drive_bit(1'b1, 1'b0);
    endtask

    // Push one byte with loopback on, check every bit centre on tx, then the looped-back RX entry.
    task automatic tx_frame_check(input string name, input logic [7:0] d, input logic pe,
                                  input logic po, input logic ts);
        int w;
        frame_bits(d, pe, po, ts);
        rx_drv  = 1'b1;
        loop_en = 1'b1;
        push_tx(d);
        w = 0;
        while (tx_w !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check({name, "_start"}, tx_w, 1'b0);
        check({name, "_latency"}, (w <= cur_div + 2), 1'b1);
        repeat (bit_clks / 2) @(negedge clk);
        for (int i = 0; i < exp_bits.size(); i++) begin
            check($sformatf("%s_bit%0d", name, i), tx_w, exp_bits[i]);
            if (i == exp_bits.size() - 1) check({name, "_busy_stop"}, bus.tx_busy, 1'b1);
            repeat (bit_clks) @(negedge clk);
        end
        check({name, "_busy_end"}, bus.tx_busy, 1'b0);
        check({name, "_idle"}, tx_w, 1'b1);
        check_rx({name, "_loop"}, d, 1'b0, 1'b0);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int lows;
        rst = 1'b1;
        loop_en = 1'b0;
        rx_drv = 1'b1;
        bus.divisor = '0;
        bus.parity_en = 1'b0;
        bus.parity_odd = 1'b0;
        bus.two_stop = 1'b0;
        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        bus.overrun_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_w, 1'b1);
        check("rst_tx_ready", bus.tx_ready, 1'b1);
        check("rst_tx_busy", bus.tx_busy, 1'b0);
        check("rst_rx_valid", bus.rx_valid, 1'b0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_perr", bus.rx_parity_err, 1'b0);
        check("rst_ferr", bus.rx_frame_err, 1'b0);
        check("rst_overrun", bus.rx_overrun, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        set_cfg(0, 1'b0, 1'b0, 1'b0);
        tx_frame_check("tx_a5_8n1", 8'hA5, 1'b0, 1'b0, 1'b0);
        set_cfg(0, 1'b1, 1'b0, 1'b0);
        tx_frame_check("tx_03_even", 8'h03, 1'b1, 1'b0, 1'b0);
        set_cfg(0, 1'b1, 1'b1, 1'b0);
        tx_frame_check("tx_03_odd", 8'h03, 1'b1, 1'b1, 1'b0);
        set_cfg(1, 1'b0, 1'b0, 1'b1);
        tx_frame_check("tx_5a_2stop", 8'h5A, 1'b0, 1'b0, 1'b1);

        vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
        vt[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8'h03, 1'b1, 1'b0};
        vt[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1, 8'h03, 1'b0, 1'b0};
        vt[3] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b1, -1, 8'h03, 1'b0, 1'b0};
        vt[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 8'h55, 1'b0, 1'b1};
        vt[5] = '{8'h12, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h12, 1'b0, 1'b0};
        vt[6] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1,  3, 8'h00, 1'b0, 1'b0};
        vt[7] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b0, -1, 8'h81, 1'b1, 1'b1};
        loop_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_cfg(0, vt[i].pe, vt[i].po, 1'b0);
            send_rx(vt[i].d, vt[i].pe, vt[i].pb, vt[i].sb, vt[i].gl);
            check_rx($sformatf("vec%0d", i), vt[i].ed, vt[i].eperr, vt[i].eferr);
            check($sformatf("vec%0d_empty", i), bus.rx_valid, 1'b0);
        end

        set_cfg(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (48) @(negedge clk);
        check("false_start_nopush", bus.rx_valid, 1'b0);
        send_rx(8'h3C, 1'b0, 1'b0, 1'b1, -1);
        check_rx("after_false_start", 8'h3C, 1'b0, 1'b0);

        for (int b = 0; b < 17; b++) send_rx(8'(b), 1'b0, 1'b0, 1'b1, -1);
        check("overrun_set", bus.rx_overrun, 1'b1);
        for (int b = 0; b < 16; b++) check_rx($sformatf("ovr_pop%0d", b), 8'(b), 1'b0, 1'b0);
        check("ovr_drained", bus.rx_valid, 1'b0);
        check("overrun_sticky", bus.rx_overrun, 1'b1);
        @(negedge clk);
        bus.overrun_clr = 1'b1;
        @(negedge clk);
        bus.overrun_clr = 1'b0;
        check("overrun_clr", bus.rx_overrun, 1'b0);

        for (int k = 0; k < 6; k++) begin
            logic pe, po, ts;
            logic [7:0] d;
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            ts = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            set_cfg(int'($urandom_range(0, 2)), pe, po, ts);
            tx_frame_check($sformatf("rnd_tx%0d", k), d, pe, po, ts);
        end

        loop_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic pe, po, pb, sb;
            logic [7:0] d;
            rx_exp_t e;
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            set_cfg(int'($urandom_range(0, 2)), pe, po, 1'b0);
            send_rx(d, pe, pb, sb, -1);
            e.d    = d;
            e.perr = pe && (pb != (^d ^ po));
            e.ferr = !sb;
            rx_q.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            rx_exp_t e;
            e = rx_q.pop_front();
            check_rx($sformatf("rnd_rx%0d", k), e.d, e.perr, e.ferr);
        end
        check("rnd_rx_empty", bus.rx_valid, 1'b0);
        check("rnd_rx_no_overrun", bus.rx_overrun, 1'b0);

        set_cfg(0, 1'b0, 1'b0, 1'b1);
        rx_drv  = 1'b1;
        loop_en = 1'b0;
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        w = 0;
        while (tx_w !== 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("mid_reset_first_start", tx_w, 1'b0);
        repeat (11 * 16 + 40) @(negedge clk);
        check("mid_reset_busy_before", bus.tx_busy, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_reset_tx", tx_w, 1'b1);
        check("mid_reset_busy", bus.tx_busy, 1'b0);
        check("mid_reset_ready", bus.tx_ready, 1'b1);
        check("mid_reset_rx_valid", bus.rx_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (tx_w !== 1'b1) lows++;
        end
        check("mid_reset_no_frames", lows, 0);
        check("mid_reset_busy_after", bus.tx_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
